scanner_ctrl_param: RTL and testbench

Parametrised next-generation scan controller. It captures a burst of WIDTH-bit samples into an internal DEPTH-entry buffer and drives the low-power, standby, active, idle, flush and transfer state machine. It streams the captured words out on request and raises configurable early-warning and start handshakes toward a peer (second) buffer. It replaces the fixed 8-bit, 10-entry scanner in multi-scanner systems.

---
 rtl/scanner_ctrl_param.sv | 138 +++++++++++++
 tb/tb_scanner_ctrl_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/scanner_ctrl_param.sv
// Parametrised scan controller: captures a burst of samples into a DEPTH-entry
// buffer, streams it out on request and signals a peer buffer as it fills.
module scanner_ctrl_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 10,
  parameter int READY_AT      = 8,
  parameter int PEER_START_AT = 9,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_scan,
  input  logic             go_to_standby,
  input  logic             transfer,
  input  logic             flush_req,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CW-1:0]    level,
  output logic [2:0]       state,
  output logic             ready_to_transfer,
  output logic             ready_peer,
  output logic             start_peer,
  output logic             scan_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_LOW_POWER = 3'd0;
  localparam logic [2:0] S_ACTIVE    = 3'd1;
  localparam logic [2:0] S_STANDBY   = 3'd2;
  localparam logic [2:0] S_IDLE      = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_TRANSFER  = 3'd5;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_LVL  = CW'(READY_AT);
  localparam logic [CW-1:0] PEER_LVL = CW'(PEER_START_AT);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    level_inc;
  logic             wr_en;

  assign level_inc = level + 1'b1;
  // ACTIVE never sees level == DEPTH, so the write index stays in range.
  assign wr_en     = (state == S_ACTIVE) && !transfer;

  always_ff @(posedge clk) begin
    if (wr_en) mem[level[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_LOW_POWER;
      level             <= '0;
      rd_ptr            <= '0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      ready_to_transfer <= 1'b0;
      ready_peer        <= 1'b0;
      start_peer        <= 1'b0;
      scan_done         <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        S_LOW_POWER: begin
          ready_to_transfer <= 1'b0;
          ready_peer        <= 1'b0;
          start_peer        <= 1'b0;
          if (start_scan && !transfer) begin
            state <= S_ACTIVE;
            level <= '0;
          end else if (go_to_standby) begin
            state <= S_STANDBY;
          end
        end
        S_STANDBY: begin
          if (start_scan) begin
            state <= S_ACTIVE;
            level <= '0;
          end
        end
        S_ACTIVE: begin
          if (transfer) begin
            state      <= S_TRANSFER;
            rd_ptr     <= '0;
            ready_peer <= 1'b0;
            start_peer <= 1'b0;
          end else begin
            // Flags follow the level this write produces.
            level             <= level_inc;
            ready_to_transfer <= (level_inc >= RDY_LVL);
            ready_peer        <= (level_inc >= RDY_LVL);
            start_peer        <= (level_inc >= PEER_LVL);
            if (level_inc == FULL_LVL) begin
              state     <= S_IDLE;
              scan_done <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          ready_to_transfer <= 1'b1;
          ready_peer        <= 1'b0;
          start_peer        <= 1'b0;
          if (transfer) begin
            state  <= S_TRANSFER;
            rd_ptr <= '0;
          end else if (flush_req) begin
            state <= S_FLUSH;
          end
        end
        S_TRANSFER: begin
          if (rd_ptr < level) begin
            data_out   <= mem[rd_ptr[AW-1:0]];
            data_valid <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
            // Launching the final word also returns to LOW_POWER.
            if (rd_ptr == level - 1'b1) begin
              state <= S_LOW_POWER;
              level <= '0;
            end
          end else begin
            state <= S_LOW_POWER;
            level <= '0;
          end
        end
        S_FLUSH: begin
          if (level == '0) state <= S_LOW_POWER;
          else             level <= level - 1'b1;
        end
        default: state <= S_LOW_POWER;
      endcase
    end
  end

endmodule

// File: tb/tb_scanner_ctrl_param.sv
// Bench for scanner_ctrl_param: default instance plus a WIDTH=16, DEPTH=4 instance.
module tb_scanner_ctrl_param;

  logic clk = 1'b0;
  logic rst, start_scan, go_to_standby, transfer, flush_req;
  logic [7:0]  din_a, dout_a;
  logic [15:0] din_b, dout_b;
  logic [3:0]  level_a;
  logic [2:0]  level_b;
  logic [2:0]  state_a, state_b;
  logic dv_a, rtt_a, rp_a, sp_a, sd_a;
  logic dv_b, rtt_b, rp_b, sp_b, sd_b;

  int total = 0;
  int bad   = 0;
  logic [7:0]  qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  scanner_ctrl_param u_a (
    .clk(clk), .rst(rst), .start_scan(start_scan), .go_to_standby(go_to_standby),
    .transfer(transfer), .flush_req(flush_req), .data_in(din_a),
    .data_out(dout_a), .data_valid(dv_a), .level(level_a), .state(state_a),
    .ready_to_transfer(rtt_a), .ready_peer(rp_a), .start_peer(sp_a), .scan_done(sd_a)
  );

  scanner_ctrl_param #(.WIDTH(16), .DEPTH(4), .READY_AT(2), .PEER_START_AT(4)) u_b (
    .clk(clk), .rst(rst), .start_scan(start_scan), .go_to_standby(go_to_standby),
    .transfer(transfer), .flush_req(flush_req), .data_in(din_b),
    .data_out(dout_b), .data_valid(dv_b), .level(level_b), .state(state_b),
    .ready_to_transfer(rtt_b), .ready_peer(rp_b), .start_peer(sp_b), .scan_done(sd_b)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    total++; if (state_a !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_a); end
    total++; if (level_a !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_a); end
    total++; if (dv_a !== 1'b0 || dout_a !== 8'h00) begin bad++; $display("FAIL reset_data dv=%0b dout=%h exp 0/00", dv_a, dout_a); end
    total++; if ({rtt_a, rp_a, sp_a, sd_a} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rtt_a, rp_a, sp_a, sd_a}); end
    rst = 1'b1;
  endtask

  task automatic test_fill(input logic [7:0] base, input int n);
    int lv;
    start_scan = 1'b1;
    step();
    start_scan = 1'b0;
    total++; if (state_a !== 3'd1 || level_a !== 4'd0) begin bad++; $display("FAIL fill_enter state=%0d level=%0d exp 1/0", state_a, level_a); end
    for (int i = 0; i < n; i++) begin
      din_a = base + 8'(i);
      qa.push_back(din_a);
      step();
      lv = i + 1;
      total++; if (level_a !== 4'(lv)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level_a, lv); end
      total++; if (rtt_a !== (lv >= 8) || rp_a !== (lv >= 8)) begin bad++; $display("FAIL fill_ready lv=%0d rtt=%0b rp=%0b exp=%0b", lv, rtt_a, rp_a, lv >= 8); end
      if (lv < 10) begin
        total++; if (sp_a !== (lv >= 9)) begin bad++; $display("FAIL fill_start_peer lv=%0d got=%0b exp=%0b", lv, sp_a, lv >= 9); end
      end
      total++; if (sd_a !== (lv == 10)) begin bad++; $display("FAIL fill_scan_done lv=%0d got=%0b exp=%0b", lv, sd_a, lv == 10); end
      total++; if (state_a !== ((lv == 10) ? 3'd3 : 3'd1)) begin bad++; $display("FAIL fill_state lv=%0d got=%0d", lv, state_a); end
    end
    din_a = 8'hEE;
    if (n == 10) begin
      step();
      total++; if (sd_a !== 1'b0 || state_a !== 3'd3 || rtt_a !== 1'b1) begin bad++; $display("FAIL idle_hold sd=%0b state=%0d rtt=%0b exp 0/3/1", sd_a, state_a, rtt_a); end
      total++; if (level_a !== 4'd10) begin bad++; $display("FAIL idle_level got=%0d exp=10", level_a); end
    end
  endtask

  task automatic test_readout(input int n, input logic with_flush);
    logic [7:0] exp;
    transfer  = 1'b1;
    flush_req = with_flush;
    step();
    transfer  = 1'b0;
    flush_req = 1'b0;
    total++; if (state_a !== 3'd5 || level_a !== 4'(n)) begin bad++; $display("FAIL xfer_enter state=%0d level=%0d exp 5/%0d", state_a, level_a, n); end
    for (int i = 0; i < n; i++) begin
      step();
      exp = (qa.size() > 0) ? qa.pop_front() : 8'hXX;
      total++; if (dv_a !== 1'b1 || dout_a !== exp) begin bad++; $display("FAIL xfer_word%0d dv=%0b dout=%h exp 1/%h", i, dv_a, dout_a, exp); end
    end
    total++; if (state_a !== 3'd0 || level_a !== 4'd0) begin bad++; $display("FAIL xfer_exit state=%0d level=%0d exp 0/0", state_a, level_a); end
    step();
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL xfer_dv_drop got=%0b exp=0", dv_a); end
  endtask

  task automatic test_flush();
    test_fill(8'h20, 10);
    qa.delete();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    total++; if (state_a !== 3'd4 || level_a !== 4'd10) begin bad++; $display("FAIL flush_enter state=%0d level=%0d exp 4/10", state_a, level_a); end
    for (int k = 1; k <= 10; k++) begin
      step();
      total++; if (level_a !== 4'(10 - k) || dv_a !== 1'b0 || state_a !== 3'd4) begin bad++; $display("FAIL flush_count k=%0d level=%0d dv=%0b state=%0d", k, level_a, dv_a, state_a); end
    end
    step();
    total++; if (state_a !== 3'd0 || level_a !== 4'd0) begin bad++; $display("FAIL flush_exit state=%0d level=%0d exp 0/0", state_a, level_a); end
  endtask

  task automatic test_standby();
    go_to_standby = 1'b1;
    step();
    go_to_standby = 1'b0;
    total++; if (state_a !== 3'd2) begin bad++; $display("FAIL standby_enter got=%0d exp=2", state_a); end
    start_scan = 1'b1;
    step();
    start_scan = 1'b0;
    total++; if (state_a !== 3'd1 || level_a !== 4'd0) begin bad++; $display("FAIL standby_start state=%0d level=%0d exp 1/0", state_a, level_a); end
    transfer = 1'b1;
    step();
    transfer = 1'b0;
    step();
    total++; if (state_a !== 3'd0 || dv_a !== 1'b0) begin bad++; $display("FAIL empty_xfer state=%0d dv=%0b exp 0/0", state_a, dv_a); end
    start_scan = 1'b1;
    transfer   = 1'b1;
    step();
    start_scan = 1'b0;
    transfer   = 1'b0;
    total++; if (state_a !== 3'd0) begin bad++; $display("FAIL scan_with_xfer got=%0d exp=0", state_a); end
  endtask

  task automatic test_cfg_reset();
    logic [15:0] exp;
    rst = 1'b0;
    step();
    rst = 1'b1;
    start_scan = 1'b1;
    step();
    start_scan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_b = 16'h1000 + 16'(i) * 16'h0101;
      qb.push_back(din_b);
      step();
      total++; if (level_b !== 3'(i + 1) || rtt_b !== (i + 1 >= 2)) begin bad++; $display("FAIL cfg_fill i=%0d level=%0d rtt=%0b", i, level_b, rtt_b); end
    end
    total++; if (sp_b !== 1'b1 || sd_b !== 1'b1 || state_b !== 3'd3) begin bad++; $display("FAIL cfg_full sp=%0b sd=%0b state=%0d exp 1/1/3", sp_b, sd_b, state_b); end
    transfer = 1'b1;
    step();
    transfer = 1'b0;
    step();
    exp = qb.pop_front();
    total++; if (dv_b !== 1'b1 || dout_b !== exp) begin bad++; $display("FAIL cfg_word0 dv=%0b dout=%h exp 1/%h", dv_b, dout_b, exp); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++; if (state_b !== 3'd0 || level_b !== 3'd0) begin bad++; $display("FAIL cfg_abort state=%0d level=%0d exp 0/0", state_b, level_b); end
    total++; if (dv_b !== 1'b0 || dout_b !== 16'h0000) begin bad++; $display("FAIL cfg_abort_data dv=%0b dout=%h exp 0/0000", dv_b, dout_b); end
    total++; if ({rtt_b, rp_b, sp_b, sd_b} !== 4'b0000) begin bad++; $display("FAIL cfg_abort_flags got=%b exp=0000", {rtt_b, rp_b, sp_b, sd_b}); end
    qb.delete();
  endtask

  initial begin
    rst = 1'b0;
    start_scan = 1'b0; go_to_standby = 1'b0; transfer = 1'b0; flush_req = 1'b0;
    din_a = 8'h00; din_b = 16'h0000;
    step();
    step();
    test_reset();
    test_fill(8'h10, 10);
    test_readout(10, 1'b0);
    test_fill(8'h40, 4);
    test_readout(4, 1'b0);
    test_flush();
    test_fill(8'h30, 10);
    test_readout(10, 1'b1);
    test_standby();
    test_cfg_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
